// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter among NUM_REQ byte streams.
// A grant lasts until a byte flagged last transfers or MAX_PKT_LEN bytes have gone out.
module uart_tx_arbiter #(
    parameter int unsigned  NUM_REQ     = 4,
    parameter int unsigned  MAX_PKT_LEN = 16,
    localparam int unsigned GW          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 forced_release
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic [7:0] CNT_CAP   = 8'(MAX_PKT_LEN - 1);

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic          forced_q, forced_d;

    logic [GW-1:0] pick;
    logic [GW-1:0] cand;
    logic          pick_valid;
    logic          xfer;
    logic [7:0]    req_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[8*i +: 8];
    end

    // First valid requester scanning upward from the one after the last grant holder.
    always_comb begin
        pick       = last_grant_q;
        cand       = '0;
        pick_valid = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!pick_valid && req_valid[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Passthrough from the held requester to the transmitter.
    always_comb begin
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        req_ready = '0;
        if (state_q == ST_LOCKED) begin
            tx_data             = req_bytes[grant_q];
            tx_valid            = req_valid[grant_q];
            req_ready[grant_q]  = tx_ready;
        end
    end

    assign xfer = (state_q == ST_LOCKED) && req_valid[grant_q] && tx_ready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        byte_cnt_d   = byte_cnt_q;
        forced_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick;
                    byte_cnt_d = 8'h00;
                    state_d    = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    // A last byte landing on the cap is a normal end, not a forced one.
                    if (req_last[grant_q]) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                    end else if (byte_cnt_q == CNT_CAP) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                        forced_d     = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            byte_cnt_q   <= 8'h00;
            forced_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            byte_cnt_q   <= byte_cnt_d;
            forced_q     <= forced_d;
        end
    end

    assign busy           = (state_q == ST_LOCKED);
    assign grant_id       = grant_q;
    assign forced_release = forced_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_transmitter between NUM_REQ byte-stream requesters.
- Arbitration is per packet: a granted requester keeps the transmitter until it sends a byte flagged last, or until MAX_PKT_LEN bytes have gone out.
- Sits directly upstream of uart_transmitter. Drives its tx_data/tx_valid and observes its tx_ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_PKT_LEN, 16, maximum bytes per grant before forced release (1..255).
- GW, $clog2(NUM_REQ), width of grant_id (derived localparam).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_data  input  NUM_REQ*8  byte from requester i on bits [8i+7:8i].
- req_valid  input  NUM_REQ  requester i has a byte.
- req_last  input  NUM_REQ  current byte of requester i ends its packet.
- req_ready  output  NUM_REQ  byte of requester i is accepted this cycle.
- tx_data  output  8  byte to uart_transmitter.
- tx_valid  output  1  byte valid to uart_transmitter.
- tx_ready  input  1  from uart_transmitter: high when idle and able to accept.
- grant_id  output  GW  index of the current or most recent grant holder.
- busy  output  1  high while a grant is held (state LOCKED).
- forced_release  output  1  one-cycle pulse when a grant ends by length cap with no last byte.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, byte_cnt=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Outputs: grant_id=0, busy=0, forced_release=0, tx_valid=0, tx_data=0, req_ready=0.
  - Reset mid-packet abandons the packet. The byte already accepted by the transmitter still completes on the line; that is not this block's concern.
- Transfer definition: a byte transfers on a rising clk edge when tx_valid && tx_ready. At that edge req_ready[g] is high.
- State IDLE:
  - busy=0, tx_valid=0, tx_data=8'h00, req_ready all 0.
  - If any req_valid is set, choose the first set index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Register that index as g, set grant_id=g, byte_cnt=0, go to LOCKED.
  - Arbitration latency: 1 cycle. A valid arriving in cycle n gives busy=1 in cycle n+1.
  - With no valid set, stay in IDLE.
- State LOCKED (busy=1), outputs combinational from registered g:
  - tx_data=req_data[g].
  - tx_valid=req_valid[g].
  - req_ready[g]=tx_ready; all other req_ready=0.
  - Zero-cycle passthrough: the first byte can transfer in the first LOCKED cycle.
- On each transfer in LOCKED:
  - If req_last[g]=1: go to IDLE, last_grant<=g, forced_release stays 0.
  - Else if byte_cnt==MAX_PKT_LEN-1: go to IDLE, last_grant<=g, pulse forced_release=1 for exactly the next cycle.
  - Else: byte_cnt<=byte_cnt+1.
  - When req_last and the cap coincide, req_last wins: no forced_release.
- Grant holder with req_valid[g]=0: hold the grant indefinitely; tx_valid=0; no timeout.
- tx_ready low (UART mid-frame): tx_valid may be high; no transfer; the requester must hold req_data/req_last stable while req_valid && !req_ready.
- Minimum one IDLE cycle between packets; back-to-back packets are separated by at least one cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- Requesters that are not granted never see req_ready.
- grant_id holds its last value in IDLE.
- byte_cnt is 8 bits and never wraps: it is bounded by MAX_PKT_LEN-1.

Test Plan:
- Req0 sends 3 bytes 8'h55, 8'hAA, 8'hA2 with last on 8'hA2:
  - busy rises 1 cycle after req_valid[0].
  - Exactly 3 req_ready[0] pulses, each coinciding with tx_ready.
  - UART line shows 55, AA, A2 in order.
  - busy falls after the A2 transfer; forced_release never pulses.
- Req1 and req3 both assert a 2-byte packet in the same cycle after reset:
  - grant_id=1 first; both req1 bytes transmit before any req3 byte.
  - Then one IDLE cycle, then grant_id=3.
- All 4 requesters continuously valid with 1-byte packets (last=1): grant order 0,1,2,3,0,1 over 6 packets.
- Req2 streams 20 bytes with last never set, MAX_PKT_LEN=16:
  - forced_release pulses once after the 16th transfer.
  - If req0 is valid, it is granted next; req2 is re-granted later for the remaining 4 bytes.
- Reset asserted mid-packet (after byte 2 of 5):
  - busy, tx_valid and req_ready go 0 immediately.
  - After release, req0 wins over a simultaneous req1 request.
- Granted requester drops req_valid for 50 cycles mid-packet:
  - grant held, busy=1, tx_valid=0 throughout, no other requester is served.
  - The packet resumes when req_valid[g] returns.
